// File: rtl/can_tx_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : can_tx_sched_if
//  Description : Mailbox-side and bit-engine-side signal bundle for the CAN
//                transmit scheduler. The scheduler uses the slave modport.
//                The host/engine side (or a testbench) uses the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface can_tx_sched_if;

  // Host mailbox side
  logic [3:0]  mb_valid_i;   // bit n: mailbox n holds a pending frame
  logic [43:0] mb_id_i;      // 11-bit ID of mailbox n at [11n+10:11n]
  logic [3:0]  mb_abort_i;   // bit n: host asks to abort mailbox n (level)
  logic [3:0]  mb_clr_o;     // one-cycle pulse: mailbox n finished
  logic [7:0]  mb_status_o;  // 2-bit result per mailbox at [2n+1:2n]

  // CAN bit engine side
  logic        tx_req_o;     // frame request
  logic [1:0]  tx_sel_o;     // mailbox being requested/transmitted
  logic [10:0] tx_id_o;      // ID latched at selection
  logic        tx_ack_i;     // engine accepted the request (SOF started)
  logic        tx_done_i;    // frame ended successfully
  logic        tx_lost_i;    // arbitration lost
  logic        tx_err_i;     // bus/ACK error

  logic        busy_o;       // scheduler not idle

  // Scheduler view
  modport slave (
    input  mb_valid_i, mb_id_i, mb_abort_i,
    input  tx_ack_i, tx_done_i, tx_lost_i, tx_err_i,
    output mb_clr_o, mb_status_o,
    output tx_req_o, tx_sel_o, tx_id_o, busy_o
  );

  // Host / engine view
  modport master (
    output mb_valid_i, mb_id_i, mb_abort_i,
    output tx_ack_i, tx_done_i, tx_lost_i, tx_err_i,
    input  mb_clr_o, mb_status_o,
    input  tx_req_o, tx_sel_o, tx_id_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/can_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : can_tx_sched
//  Description : Four-mailbox CAN transmit scheduler. Picks the pending
//                mailbox with the lowest ID (lowest index on ties), requests
//                it from the bit engine, and retries on arbitration loss or
//                error until success, abort, or the error retry limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module can_tx_sched #(
  parameter int unsigned RETRY_LIMIT = 15   // 1..15 error-terminated attempts
) (
  input  wire logic         wb_clk_i,
  input  wire logic         wb_rst_i,
  can_tx_sched_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_REQ    = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT_C      = 4'(RETRY_LIMIT);
  localparam logic [1:0] STAT_SENT    = 2'b01;
  localparam logic [1:0] STAT_ABORTED = 2'b10;
  localparam logic [1:0] STAT_FAILED  = 2'b11;

  state_t      state_q,  state_d;
  logic [1:0]  sel_q,    sel_d;
  logic [10:0] id_q,     id_d;
  logic [3:0]  retry_q,  retry_d;
  logic [3:0]  clr_q,    clr_d;
  logic [7:0]  status_q, status_d;

  // A mailbox competes only while pending and not being aborted.
  logic [3:0]  elig;
  assign elig = bus.mb_valid_i & ~bus.mb_abort_i;

  logic        win_found;
  logic [1:0]  win_idx;
  logic [10:0] win_id;

  // Lowest-ID search; strict less-than keeps the lower index on equal IDs.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    win_id    = 11'd0;
    for (int n = 0; n < 4; n++) begin
      if (elig[n] && (!win_found || (bus.mb_id_i[11*n +: 11] < win_id))) begin
        win_found = 1'b1;
        win_idx   = 2'(n);
        win_id    = bus.mb_id_i[11*n +: 11];
      end
    end
  end

  logic       abort_sel;
  logic [3:0] retry_inc;
  assign abort_sel = bus.mb_abort_i[sel_q];
  assign retry_inc = retry_q + 4'd1;

  logic       fin;
  logic [1:0] fin_code;

  // Next-state, selection latching, retry accounting and completion reporting.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    id_d     = id_q;
    retry_d  = retry_q;
    clr_d    = 4'b0000;
    status_d = status_q;
    fin      = 1'b0;
    fin_code = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (|elig) state_d = ST_SELECT;
      end

      ST_SELECT: begin
        if (win_found) begin
          sel_d = win_idx;
          id_d  = win_id;
          // The retry count belongs to one mailbox; a new winner starts fresh.
          if (win_idx != sel_q) retry_d = 4'd0;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        // Acceptance beats an abort raised in the same cycle.
        if (bus.tx_ack_i) begin
          state_d = ST_ACTIVE;
        end else if (abort_sel) begin
          fin      = 1'b1;
          fin_code = STAT_ABORTED;
        end
      end

      ST_ACTIVE: begin
        // Abort is only honoured at frame end, and only instead of a retry.
        if (bus.tx_done_i) begin
          fin      = 1'b1;
          fin_code = STAT_SENT;
        end else if (bus.tx_lost_i) begin
          if (abort_sel) begin
            fin      = 1'b1;
            fin_code = STAT_ABORTED;
          end else begin
            state_d = ST_SELECT;
          end
        end else if (bus.tx_err_i) begin
          // An abort pending at an error end takes precedence over failing.
          if (abort_sel) begin
            fin      = 1'b1;
            fin_code = STAT_ABORTED;
          end else if (retry_inc == LIMIT_C) begin
            fin      = 1'b1;
            fin_code = STAT_FAILED;
          end else begin
            retry_d = retry_inc;
            state_d = ST_SELECT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      clr_d                      = 4'b0001 << sel_q;
      status_d[{sel_q, 1'b0} +: 2] = fin_code;
      retry_d                    = 4'd0;
      state_d                    = ST_IDLE;
    end
  end

  // State and datapath registers; reset abandons any frame without reporting.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      sel_q    <= 2'd0;
      id_q     <= 11'd0;
      retry_q  <= 4'd0;
      clr_q    <= 4'b0000;
      status_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      id_q     <= id_d;
      retry_q  <= retry_d;
      clr_q    <= clr_d;
      status_q <= status_d;
    end
  end

  assign bus.tx_req_o    = (state_q == ST_REQ);
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.tx_sel_o    = sel_q;
  assign bus.tx_id_o     = id_q;
  assign bus.mb_clr_o    = clr_q;
  assign bus.mb_status_o = status_q;

`ifndef SYNTHESIS
  a_clr_onehot : assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    $onehot0(clr_q));
  a_clr_idle   : assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    (|clr_q) |-> (state_q == ST_IDLE));
  a_retry_rng  : assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    retry_q < LIMIT_C);
`endif

endmodule
`default_nettype wire

// File: tb/tb_can_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_can_tx_sched
//  Description : Scoreboard bench for can_tx_sched. A driver plays host and
//                bit engine and pushes expected requests/completions computed
//                from a mailbox-level model; a monitor compares DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_can_tx_sched;

  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  can_tx_sched_if bus();

  can_tx_sched #(.RETRY_LIMIT(LIMIT)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  typedef struct { int idx; logic [10:0] id; } req_t;
  typedef struct { int idx; logic [7:0] status; } cmp_t;

  req_t req_q[$];
  cmp_t cmp_q[$];

  int checks   = 0;
  int failures = 0;
  bit dead     = 0;

  // Mailbox-level model
  logic [3:0]  m_valid;
  logic [3:0]  m_abort;
  logic [10:0] m_id [4];
  logic [7:0]  m_status;
  int          cur;    // mailbox selected last
  int          cnt;    // error-terminated attempts of the current mailbox
  int          w_exp;  // mailbox expected in the next request

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic apply();
    bus.mb_valid_i = m_valid;
    bus.mb_abort_i = m_abort;
    for (int n = 0; n < 4; n++) bus.mb_id_i[11*n +: 11] = m_id[n];
  endtask

  // Winner = eligible mailbox minimising (ID, index).
  function automatic int winner();
    int best = -1;
    int bestkey = 32'h7fff_ffff;
    for (int n = 0; n < 4; n++) begin
      if (m_valid[n] && !m_abort[n]) begin
        int key;
        key = int'(m_id[n]) * 4 + n;
        if (key < bestkey) begin
          bestkey = key;
          best = n;
        end
      end
    end
    return best;
  endfunction

  task automatic expect_select();
    int w;
    req_t r;
    w = winner();
    if (w < 0) return;
    if (w != cur) cnt = 0;
    cur   = w;
    w_exp = w;
    r.idx = w;
    r.id  = m_id[w];
    req_q.push_back(r);
  endtask

  task automatic complete(input int w, input logic [1:0] code);
    cmp_t c;
    m_status[2*w +: 2] = code;
    cnt      = 0;
    c.idx    = w;
    c.status = m_status;
    cmp_q.push_back(c);
  endtask

  function automatic logic [10:0] rand_id();
    if ($urandom_range(0, 1) == 0) return 11'($urandom_range(0, 7));
    return 11'($urandom_range(0, 2047));
  endfunction

  task automatic add_mailbox(input bit hi);
    int s;
    if (hi) begin
      m_valid[3] = 1'b1;
      m_id[3]    = 11'h001;
      return;
    end
    s = $urandom_range(0, 3);
    for (int k = 0; k < 4; k++) begin
      if (!m_valid[(s + k) % 4]) begin
        m_valid[(s + k) % 4] = 1'b1;
        m_id[(s + k) % 4]    = rand_id();
        return;
      end
    end
  endtask

  task automatic refill();
    for (int n = 0; n < 4; n++) begin
      if (!m_valid[n] && $urandom_range(0, 1) == 1) begin
        m_valid[n] = 1'b1;
        m_id[n]    = rand_id();
      end
    end
    if (m_valid == 4'b0000) add_mailbox(1'b0);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (bus.tx_req_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL req_timeout actual=no_request required=request_within_40_cycles");
    end
  endtask

  // One request/response round. kind: 0 done, 1 done+lost+err, 2 lost, 3 err,
  // 4 abort in REQ, 5 abort in ACTIVE then done, 6 abort in ACTIVE then lost/err,
  // 7 abort together with ack then done.
  task automatic attempt(input int kind, input bit add_hi, output bit completed);
    bit ok;
    int w;
    bit ab;
    completed = 1'b0;
    wait_req(ok);
    if (!ok) begin
      dead = 1'b1;
      return;
    end
    w = w_exp;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if (kind == 4) begin
      m_abort[w] = 1'b1;
      apply();
      complete(w, 2'b10);
      @(negedge clk);
      check("req_drop_on_abort", bus.tx_req_o, 0);
      m_valid[w] = 1'b0;
      m_abort[w] = 1'b0;
      apply();
      completed = 1'b1;
      return;
    end
    if (kind == 7) begin
      m_abort[w] = 1'b1;
      apply();
    end
    bus.tx_ack_i = 1'b1;
    @(negedge clk);
    bus.tx_ack_i = 1'b0;
    check("req_low_after_ack", bus.tx_req_o, 0);
    check("busy_in_active", bus.busy_o, 1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    if (kind == 5 || kind == 6) begin
      m_abort[w] = 1'b1;
      apply();
      @(negedge clk);
    end
    ab = m_abort[w];
    case (kind)
      0, 5, 7: begin
        bus.tx_done_i = 1'b1;
        complete(w, 2'b01);
        completed = 1'b1;
      end
      1: begin
        bus.tx_done_i = 1'b1;
        bus.tx_lost_i = 1'b1;
        bus.tx_err_i  = 1'b1;
        complete(w, 2'b01);
        completed = 1'b1;
      end
      2: begin
        bus.tx_lost_i = 1'b1;
        if (ab) begin complete(w, 2'b10); completed = 1'b1; end
      end
      3: begin
        bus.tx_err_i = 1'b1;
        if (ab) begin
          complete(w, 2'b10);
          completed = 1'b1;
        end else if (cnt + 1 == LIMIT) begin
          complete(w, 2'b11);
          completed = 1'b1;
        end else begin
          cnt = cnt + 1;
        end
      end
      default: begin
        if ($urandom_range(0, 1) == 0) bus.tx_lost_i = 1'b1;
        else bus.tx_err_i = 1'b1;
        complete(w, 2'b10);
        completed = 1'b1;
      end
    endcase
    if (!completed) begin
      if (add_hi || $urandom_range(0, 3) == 0) add_mailbox(add_hi);
      apply();
      expect_select();
    end
    @(negedge clk);
    bus.tx_done_i = 1'b0;
    bus.tx_lost_i = 1'b0;
    bus.tx_err_i  = 1'b0;
    if (completed) begin
      m_valid[w] = 1'b0;
      m_abort[w] = 1'b0;
      apply();
    end
  endtask

  task automatic serve(input int kind, input bit add_hi, input bit do_refill);
    bit c;
    if (dead) return;
    attempt(kind, add_hi, c);
    if (c && !dead) begin
      if (do_refill) refill();
      apply();
      expect_select();
    end
  endtask

  // Monitor: compare each new request and each completion pulse.
  initial begin
    bit   prev;
    req_t r;
    cmp_t c;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (bus.tx_req_o === 1'b1 && !prev) begin
          if (req_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_request actual_sel=%0d required=none", bus.tx_sel_o);
          end else begin
            r = req_q.pop_front();
            check("req_sel", 32'(bus.tx_sel_o), r.idx);
            check("req_id", 32'(bus.tx_id_o), 32'(r.id));
            check("req_busy", 32'(bus.busy_o), 1);
          end
        end
        prev = (bus.tx_req_o === 1'b1);
        if (bus.mb_clr_o !== 4'b0000) begin
          if (cmp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_clr actual=0x%0h required=0x0", bus.mb_clr_o);
          end else begin
            c = cmp_q.pop_front();
            check("clr_pulse", 32'(bus.mb_clr_o), 32'(4'b0001 << c.idx));
            check("status", 32'(bus.mb_status_o), 32'(c.status));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"},    32'(bus.tx_req_o), 0);
    check({tag, "_sel"},    32'(bus.tx_sel_o), 0);
    check({tag, "_id"},     32'(bus.tx_id_o), 0);
    check({tag, "_clr"},    32'(bus.mb_clr_o), 0);
    check({tag, "_status"}, 32'(bus.mb_status_o), 0);
    check({tag, "_busy"},   32'(bus.busy_o), 0);
  endtask

  initial begin
    bit ok;
    m_valid = 4'b0; m_abort = 4'b0; m_status = 8'h00;
    for (int n = 0; n < 4; n++) m_id[n] = 11'd0;
    cur = 0; cnt = 0; w_exp = 0;
    bus.tx_ack_i = 1'b0; bus.tx_done_i = 1'b0;
    bus.tx_lost_i = 1'b0; bus.tx_err_i = 1'b0;
    apply();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Lowest ID wins: mb2 (0x100) before mb0 (0x123)
    m_valid = 4'b0101; m_id[0] = 11'h123; m_id[2] = 11'h100;
    apply(); expect_select();
    serve(0, 0, 0);
    serve(0, 0, 0);

    // Equal IDs: lower index first
    m_valid = 4'b1010; m_id[1] = 11'h050; m_id[3] = 11'h050;
    apply(); expect_select();
    serve(0, 0, 0);
    serve(0, 0, 0);

    // Error retries to the limit with an arbitration loss in between
    m_valid = 4'b0001; m_id[0] = 11'h2aa;
    apply(); expect_select();
    serve(3, 0, 0); serve(2, 0, 0); serve(3, 0, 0); serve(3, 0, 0);

    // Abort in REQ, then abort ignored in ACTIVE
    m_valid = 4'b0001; m_id[0] = 11'h011;
    apply(); expect_select();
    serve(4, 0, 0);
    m_valid = 4'b0001;
    apply(); expect_select();
    serve(5, 0, 0);

    // Higher-priority mailbox appears on arbitration loss; count restarts
    m_valid = 4'b0001; m_id[0] = 11'h200;
    apply(); expect_select();
    serve(3, 0, 0); serve(2, 1, 0);
    serve(3, 0, 0); serve(3, 0, 0); serve(0, 0, 0);
    serve(3, 0, 0); serve(0, 0, 0);

    // Randomised traffic
    if (!dead) begin
      refill(); apply(); expect_select();
      repeat (200) serve($urandom_range(0, 7), 0, 1);
    end

    // Asynchronous reset during a frame
    if (!dead) begin
      wait_req(ok);
      if (ok) begin
        bus.tx_ack_i = 1'b1;
        @(negedge clk);
        bus.tx_ack_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero_outputs("async_reset");
        req_q.delete(); cmp_q.delete();
        m_valid = 4'b0; m_abort = 4'b0; m_status = 8'h00; cur = 0; cnt = 0;
        apply();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("after_reset");
        m_valid = 4'b0100; m_id[2] = rand_id();
        apply(); expect_select();
        serve(0, 0, 0);
      end
    end

    repeat (6) @(negedge clk);
    check("pending_requests", req_q.size(), 0);
    check("pending_completions", cmp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/can_tx_sched.md
CAN_TX_SCHED -- requirements
Module: can_tx_sched

Interface
REQ-001 SHALL have parameter RETRY_LIMIT, default 15, range 1..15: number of error-terminated attempts allowed before a mailbox is failed.
REQ-002 SHALL have port wb_clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port mb_valid_i  input  4  bit n=1: mailbox n holds a pending frame.
REQ-005 SHALL have port mb_id_i  input  44  11-bit standard ID of mailbox n at [11n+10:11n].
REQ-006 SHALL have port mb_abort_i  input  4  bit n=1: host requests abort of mailbox n (level).
REQ-007 SHALL have port mb_clr_o  output  4  one-cycle pulse: mailbox n finished; host clears mb_valid_i[n].
REQ-008 SHALL have port mb_status_o  output  8  2-bit result per mailbox at [2n+1:2n]: 00 none, 01 sent, 10 aborted, 11 failed.
REQ-009 SHALL have port tx_req_o  output  1  frame request to the CAN bit engine.
REQ-010 SHALL have port tx_sel_o  output  2  index of the mailbox being requested/transmitted.
REQ-011 SHALL have port tx_id_o  output  11  ID of the selected mailbox, latched at selection.
REQ-012 SHALL have port tx_ack_i  input  1  engine accepted the request (SOF started).
REQ-013 SHALL have ports tx_done_i, tx_lost_i, tx_err_i  input  1 each  end of frame: success, arbitration lost, bus/ACK error.
REQ-014 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SELECT, REQ, ACTIVE.
REQ-016 IDLE: when any n has mb_valid_i[n]=1 and mb_abort_i[n]=0, SHALL go to SELECT next cycle.
REQ-017 SELECT (exactly 1 cycle): SHALL latch the eligible mailbox with numerically lowest ID into tx_sel_o/tx_id_o; ties SHALL go to the lowest index; with no eligible mailbox SHALL return to IDLE.
REQ-018 SELECT: if the winner differs from the previously selected mailbox, retry counter SHALL clear to 0.
REQ-019 REQ: tx_req_o SHALL be 1 only in this state; on tx_ack_i=1 SHALL go to ACTIVE with tx_req_o low the following cycle.
REQ-020 REQ: if mb_abort_i[sel]=1 and tx_ack_i=0, SHALL drop tx_req_o, pulse mb_clr_o[sel], set status 10, go to IDLE; simultaneous tx_ack_i=1 SHALL win (go to ACTIVE).
REQ-021 ACTIVE: tx_done_i SHALL set status[sel]=01, pulse mb_clr_o[sel], go to IDLE; done SHALL take priority over simultaneous lost/err.
REQ-022 ACTIVE: tx_lost_i (without done) SHALL return to SELECT without incrementing the retry counter.
REQ-023 ACTIVE: tx_err_i (without done/lost) SHALL increment the 4-bit retry counter; if new value equals RETRY_LIMIT SHALL set status 11, pulse clr, go to IDLE, else go to SELECT.
REQ-024 mb_abort_i SHALL be ignored in ACTIVE; on a lost/err end with abort[sel] asserted, SHALL set status 10, pulse clr, go to IDLE instead of retrying.
REQ-025 Each completion SHALL clear the retry counter; mb_status_o fields SHALL hold until overwritten by that mailbox's next completion.
REQ-026 At most one mb_clr_o bit SHALL be high in any cycle; tx_sel_o/tx_id_o SHALL be stable while tx_req_o=1 or in ACTIVE.

Reset
REQ-027 On wb_rst_i=1, asynchronously: state IDLE, tx_req_o=0, tx_sel_o=0, tx_id_o=0, mb_clr_o=0, mb_status_o=0, busy_o=0, retry counter=0; a frame in progress is abandoned without status update.

Verification
REQ-028 valid=0101, IDs mb0=0x123, mb2=0x100 -> SELECT picks sel=2, tx_id_o=0x100; ack then done -> clr=0100 one cycle, status[5:4]=01, then mb0 requested.
REQ-029 mb1 and mb3 both ID 0x050 -> sel=1 first.
REQ-030 RETRY_LIMIT=3, tx_err_i on each attempt -> 3 requests, then status=11, one clr pulse; tx_lost_i interleaved does not count.
REQ-031 abort[0] in REQ before ack -> tx_req_o drops next cycle, status[1:0]=10; abort in ACTIVE then tx_done_i -> status 01.
REQ-032 tx_lost_i while higher-priority mb3 (ID 0x001) becomes valid -> re-SELECT picks sel=3, retry counter 0.
REQ-033 wb_rst_i pulsed in ACTIVE mid-cycle -> all outputs 0 immediately, no clr pulse.
